// File: rtl/hash_nonce_scheduler.sv
// hash_nonce_scheduler
//   Runs a nonce search on the micro_ucr_hash core. It presents 12 header bytes
//   plus a 4-byte nonce to the core and waits HASH_LAT cycles. It then compares
//   hash bytes 0 and 1 against the target and moves to the next nonce until a
//   hit occurs or the nonce reaches 32'hFFFFFFFF.
//   Optional feature macro: HASH_SCHED_LIMIT_EN. When it is defined, the search
//   also stops after MAX_TRIES attempts.
module hash_nonce_scheduler #(
    parameter int unsigned HASH_LAT  = 3,
    parameter int unsigned MAX_TRIES = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [95:0]  header,
    input  logic [31:0]  nonce_start,
    input  logic [7:0]   target,
    input  logic [7:0]   hash_array0,
    input  logic [7:0]   hash_array1,
    input  logic [7:0]   hash_array2,
    output logic [127:0] core_data,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [23:0]  hash_out,
    output logic [31:0]  attempts
);

    localparam int unsigned      CNT_W     = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HASH_LAT - 1);
    localparam logic [31:0]      TRY_LIMIT = 32'(MAX_TRIES);
`ifdef HASH_SCHED_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [95:0]        header_q, header_d;
    logic [7:0]         target_q, target_d;
    logic [127:0]       core_data_q, core_data_d;
    logic               found_q, found_d;
    logic [31:0]        nonce_out_q, nonce_out_d;
    logic [23:0]        hash_out_q, hash_out_d;
    logic [31:0]        attempts_q, attempts_d;

    logic               start_ok;
    logic               hit;
    logic [31:0]        attempts_inc;
    logic               limit_hit;

    // Attempt counter must never roll over to 0 on very long searches.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Core bytes 12..15 carry the nonce MSB first, so byte 12 (the lowest
    // byte lane of this slice) holds nonce[31:24].
    function automatic logic [31:0] nonce_lanes(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

    assign start_ok     = start && (state_q == S_IDLE || state_q == S_DONE);
    assign hit          = (hash_array0 < target_q) && (hash_array1 < target_q);
    assign attempts_inc = sat_inc32(attempts_q);
    assign limit_hit    = LIMIT_EN && (attempts_inc >= TRY_LIMIT);

    // State and datapath registers; async reset clears everything, outputs included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nonce_q     <= '0;
            header_q    <= '0;
            target_q    <= '0;
            core_data_q <= '0;
            found_q     <= 1'b0;
            nonce_out_q <= '0;
            hash_out_q  <= '0;
            attempts_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nonce_q     <= nonce_d;
            header_q    <= header_d;
            target_q    <= target_d;
            core_data_q <= core_data_d;
            found_q     <= found_d;
            nonce_out_q <= nonce_out_d;
            hash_out_q  <= hash_out_d;
            attempts_q  <= attempts_d;
        end
    end

    // Next-state logic; abort overrides both start and a CHECK result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nonce_d     = nonce_q;
        header_d    = header_q;
        target_d    = target_q;
        core_data_d = core_data_q;
        found_d     = found_q;
        nonce_out_d = nonce_out_q;
        hash_out_d  = hash_out_q;
        attempts_d  = attempts_q;

        if (abort) begin
            state_d = S_IDLE;
            found_d = 1'b0;
        end else if (start_ok) begin
            header_d   = header;
            target_d   = target;
            nonce_d    = nonce_start;
            attempts_d = '0;
            found_d    = 1'b0;
            state_d    = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    core_data_d = {nonce_lanes(nonce_q), header_q};
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
                S_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = S_CHECK;
                end
                S_CHECK: begin
                    // Report every checked nonce so an exhausted search shows the last one.
                    attempts_d  = attempts_inc;
                    nonce_out_d = nonce_q;
                    hash_out_d  = {hash_array2, hash_array1, hash_array0};
                    if (hit) begin
                        found_d = 1'b1;
                        state_d = S_DONE;
                    end else if (nonce_q == 32'hFFFF_FFFF || limit_hit) begin
                        state_d = S_DONE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = S_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_data = core_data_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign found     = found_q;
    assign nonce_out = nonce_out_q;
    assign hash_out  = hash_out_q;
    assign attempts  = attempts_q;

endmodule

// File: tb/tb_hash_nonce_scheduler.sv
// Bench for hash_nonce_scheduler with a stub hash core of latency HASH_LAT.
// The stub returns hash_array0 = hash_array1 = core byte 15 (nonce[7:0]) and
// hash_array2 = 8'hA5.
module tb_hash_nonce_scheduler;

    localparam int HASH_LAT  = 3;
    localparam int MAX_TRIES = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [95:0]  header = '0;
    logic [31:0]  nonce_start = '0;
    logic [7:0]   target = '0;
    logic [7:0]   hash_array0, hash_array1, hash_array2;
    logic [127:0] core_data;
    logic         busy, done, found;
    logic [31:0]  nonce_out;
    logic [23:0]  hash_out;
    logic [31:0]  attempts;

    int n_vec = 0;
    int n_bad = 0;

    hash_nonce_scheduler #(.HASH_LAT(HASH_LAT), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .header(header), .nonce_start(nonce_start), .target(target),
        .hash_array0(hash_array0), .hash_array1(hash_array1), .hash_array2(hash_array2),
        .core_data(core_data), .busy(busy), .done(done), .found(found),
        .nonce_out(nonce_out), .hash_out(hash_out), .attempts(attempts)
    );

    always #5 clk = ~clk;

    // Stub core: HASH_LAT register stages on byte 15.
    logic [7:0] pipe [HASH_LAT];
    always @(posedge clk) begin
        pipe[0] <= core_data[127:120];
        for (int i = 1; i < HASH_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign hash_array0 = pipe[HASH_LAT-1];
    assign hash_array1 = pipe[HASH_LAT-1];
    assign hash_array2 = 8'hA5;

    typedef struct {
        logic [95:0] hdr;
        logic [31:0] ns;
        logic [7:0]  tgt;
        logic        exp_found;
        logic [31:0] exp_nonce;
        logic [31:0] exp_att;
        logic [23:0] exp_hash;
        logic [31:0] exp_core_hi;  // core_data[127:96] = {b15,b14,b13,b12} of final nonce
        int          exp_cyc;      // start edge to done, also busy-high cycles
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_nonce_out"}, nonce_out, 0);
        chk({tag, "_hash_out"}, hash_out, 0);
        chk({tag, "_attempts"}, attempts, 0);
        chk({tag, "_core_data"}, core_data, 0);
    endtask

    // Called 1 time unit after a rising edge; leaves the same phase.
    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        int bcyc;
        header = v.hdr; nonce_start = v.ns; target = v.tgt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d_done_cleared", id), {done, found}, 0);
        bcyc = busy ? 1 : 0;
        cyc  = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) bcyc++;
        end
        chk($sformatf("v%0d_done_seen", id), done, 1);
        chk($sformatf("v%0d_latency", id), cyc, v.exp_cyc);
        chk($sformatf("v%0d_busy_cycles", id), bcyc, v.exp_cyc);
        chk($sformatf("v%0d_found", id), found, v.exp_found);
        chk($sformatf("v%0d_nonce_out", id), nonce_out, v.exp_nonce);
        chk($sformatf("v%0d_attempts", id), attempts, v.exp_att);
        chk($sformatf("v%0d_hash_out", id), hash_out, v.exp_hash);
        chk($sformatf("v%0d_core_data", id), core_data, {v.exp_core_hi, v.hdr});
    endtask

    initial begin
        // One attempt = LOAD + HASH_LAT WAIT + CHECK = 5 cycles.
        vecs[0] = '{96'h0B0A09080706050403020100, 32'h0000_0000, 8'd5,
                    1'b1, 32'h0000_0000, 32'd1, 24'hA50000, 32'h0000_0000, 5};
`ifdef HASH_SCHED_LIMIT_EN
        // 16 tries 0x10..0x1F, all low bytes >= 5.
        vecs[1] = '{96'hDEADBEEF0123456789ABCDEF, 32'h0000_0010, 8'd5,
                    1'b0, 32'h0000_001F, 32'd16, 24'hA51F1F, 32'h1F00_0000, 80};
`else
        // 0x10..0xFF miss, 0x100 hits: 241 checks, 1205 cycles.
        vecs[1] = '{96'hDEADBEEF0123456789ABCDEF, 32'h0000_0010, 8'd5,
                    1'b1, 32'h0000_0100, 32'd241, 24'hA50000, 32'h0001_0000, 1205};
`endif
        // target 0 never hits; stop at FFFFFFFF without wrapping.
        vecs[2] = '{96'h111111112222222233333333, 32'hFFFF_FFFE, 8'd0,
                    1'b0, 32'hFFFF_FFFF, 32'd2, 24'hA5FFFF, 32'hFFFF_FFFF, 10};
        // low byte 3 < 4: immediate hit.
        vecs[3] = '{96'hCAFEF00D0000000100000002, 32'h0000_0203, 8'd4,
                    1'b1, 32'h0000_0203, 32'd1, 24'hA50303, 32'h0302_0000, 5};
        // FE, FF miss, 0x200 hits.
        vecs[4] = '{96'h0123456789ABCDEF01234567, 32'h0000_01FE, 8'd1,
                    1'b1, 32'h0000_0200, 32'd3, 24'hA50000, 32'h0002_0000, 15};
        // strict less-than: FD with target FD misses; FE, FF miss; 0x100 hits.
        vecs[5] = '{96'hA5A5A5A55A5A5A5AFFFF0000, 32'h0000_00FD, 8'hFD,
                    1'b1, 32'h0000_0100, 32'd4, 24'hA50000, 32'h0001_0000, 20};

        // Reset state
        #1 reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort in WAIT of attempt 3, with a start in the same cycle.
        header = 96'h0; nonce_start = 32'h10; target = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        // start while busy must be ignored
        nonce_start = 32'h50; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && attempts != 32'd2; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_reach_attempt2", attempts, 2);
        @(posedge clk); #1;  // LOAD -> WAIT of attempt 3
        chk("abort_in_wait_busy", busy, 1);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_found", found, 0);
        chk("abort_attempts_kept", attempts, 2);
        chk("abort_nonce_out_kept", nonce_out, 32'h11);
        chk("abort_hash_out_kept", hash_out, 24'hA51111);
        @(posedge clk); #1;
        chk("abort_stays_idle", {busy, done}, 0);
        run_vec(vecs[3], 13);

        // Reset asserted mid-WAIT, then a clean rerun of vector 0.
        header = 96'h0; nonce_start = 32'h10; target = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
